// File: rtl/cache_if.sv
// Bus bundle between the cache, its requester and the backing memory.
// The slave view is the cache; the master view is its environment
// (request source plus memory), as seen from a single clock domain.
interface cache_if;
    // Memory side
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    // Requester side
    logic        o_busy;
    logic [31:0] i_req_addr;
    logic        i_req_ren;
    logic        i_req_wen;
    logic [3:0]  i_req_mask;
    logic [31:0] i_req_wdata;
    logic [31:0] o_res_rdata;

    modport slave (
        input  i_mem_ready, i_mem_rdata, i_mem_valid,
        input  i_req_addr, i_req_ren, i_req_wen, i_req_mask, i_req_wdata,
        output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        output o_busy, o_res_rdata
    );

    modport master (
        output i_mem_ready, i_mem_rdata, i_mem_valid,
        output i_req_addr, i_req_ren, i_req_wen, i_req_mask, i_req_wdata,
        input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
        input  o_busy, o_res_rdata
    );
endinterface

// File: rtl/cache.sv
// Two-way set-associative, write-back, write-allocate data cache.
// Hits complete in the accepting cycle; misses run a small FSM that
// optionally writes the dirty victim back, refills the line word by word,
// then replays the pending read/write against the refilled line.
// Replacement keeps one MRU bit per set, so the design assumes W = 2.
module cache #(
    parameter int O = 4,    // offset bits (bytes per line = 2**O)
    parameter int S = 5,    // index bits (sets = 2**S)
    parameter int W = 2     // ways
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    cache_if.slave bus
);
    localparam int T     = 32 - O - S;          // tag width
    localparam int NSETS = 1 << S;
    localparam int WB    = O - 2;               // word-in-line bits
    localparam int WPL   = 1 << WB;             // words per line
    localparam int WAYB  = (W > 1) ? $clog2(W) : 1;
    localparam logic [WB-1:0] CNT_ONE = WB'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t r_state, w_state_next;

    // Line metadata (reset) and storage arrays (not reset)
    logic [NSETS-1:0] r_valid [W];
    logic [NSETS-1:0] r_dirty [W];
    logic [NSETS-1:0] r_mru;
    logic [T-1:0]     r_tag  [W][NSETS];
    logic [31:0]      r_data [W][NSETS*WPL];

    // Pending-miss context, captured when the miss is accepted
    logic            r_op_wen;
    logic [T-1:0]    r_req_tag;
    logic [S-1:0]    r_idx;
    logic [WB-1:0]   r_word;
    logic [3:0]      r_mask;
    logic [31:0]     r_wdata;
    logic [WAYB-1:0] r_way;
    logic [T-1:0]    r_vtag;
    logic [WB-1:0]   r_cnt;          // memory request counter
    logic [WB-1:0]   r_rsp_cnt;      // fill response counter
    logic            r_issue_done;   // all fill reads have been issued
    logic [31:0]     r_res_rdata;

    // Incoming request decode
    logic [T-1:0]    w_req_tag;
    logic [S-1:0]    w_req_idx;
    logic [WB-1:0]   w_req_word;
    logic            w_acc;
    logic [W-1:0]    w_way_hit;
    logic            w_hit;
    logic [WAYB-1:0] w_hit_way;
    logic [WAYB-1:0] w_vict;
    logic            w_vict_dirty;
    logic [31:0]     w_hit_rdata;
    logic [31:0]     w_hit_merge;
    logic [31:0]     w_done_old;
    logic [31:0]     w_done_merge;
    logic            w_hit_wr;

    // Memory-side request outputs
    logic            w_mem_ren;
    logic            w_mem_wen;
    logic [31:0]     w_mem_addr;
    logic [31:0]     w_mem_wdata;

    assign w_req_tag  = bus.i_req_addr[31:O+S];
    assign w_req_idx  = bus.i_req_addr[O+S-1:O];
    assign w_req_word = bus.i_req_addr[O-1:2];
    assign w_acc      = (r_state == ST_IDLE) && (bus.i_req_ren || bus.i_req_wen);

    // Per-way tag compare
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_way_cmp
            assign w_way_hit[gi] = r_valid[gi][w_req_idx] &&
                                   (r_tag[gi][w_req_idx] == w_req_tag);
        end
    endgenerate

    assign w_hit = |w_way_hit;

    // Encode which way hit (at most one can match)
    always_comb begin
        w_hit_way = '0;
        for (int i = 0; i < W; i++) begin
            if (w_way_hit[i]) w_hit_way = WAYB'(i);
        end
    end

    // Victim choice: lowest invalid way, else the way that is not MRU
    always_comb begin
        w_vict = ~r_mru[w_req_idx];
        for (int i = W - 1; i >= 0; i--) begin
            if (!r_valid[i][w_req_idx]) w_vict = WAYB'(i);
        end
    end

    assign w_vict_dirty = r_valid[w_vict][w_req_idx] && r_dirty[w_vict][w_req_idx];
    assign w_hit_rdata  = r_data[w_hit_way][{w_req_idx, w_req_word}];
    assign w_done_old   = r_data[r_way][{r_idx, r_word}];
    assign w_hit_wr     = w_acc && w_hit && bus.i_req_wen;

    // Byte-lane merge for write hits and for the write replayed after a fill
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_hit_merge[8*gi +: 8]  = bus.i_req_mask[gi] ? bus.i_req_wdata[8*gi +: 8]
                                                                : w_hit_rdata[8*gi +: 8];
            assign w_done_merge[8*gi +: 8] = r_mask[gi] ? r_wdata[8*gi +: 8]
                                                        : w_done_old[8*gi +: 8];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next state and memory request generation
    always_comb begin
        w_state_next = r_state;
        w_mem_ren    = 1'b0;
        w_mem_wen    = 1'b0;
        w_mem_addr   = {r_req_tag, r_idx, r_cnt, 2'b00};
        w_mem_wdata  = r_data[r_way][{r_idx, r_cnt}];
        case (r_state)
            ST_IDLE: begin
                if (w_acc && !w_hit) begin
                    w_state_next = w_vict_dirty ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                // A write is only presented when memory can take it
                w_mem_wen  = bus.i_mem_ready;
                w_mem_addr = {r_vtag, r_idx, r_cnt, 2'b00};
                if (bus.i_mem_ready && (&r_cnt)) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                w_mem_ren = bus.i_mem_ready && !r_issue_done;
                if (bus.i_mem_valid && (&r_rsp_cnt)) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Metadata, miss context, counters and read result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < W; i++) begin
                r_valid[i] <= '0;
                r_dirty[i] <= '0;
            end
            r_mru        <= '0;
            r_res_rdata  <= '0;
            r_op_wen     <= 1'b0;
            r_req_tag    <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_mask       <= '0;
            r_wdata      <= '0;
            r_way        <= '0;
            r_vtag       <= '0;
            r_cnt        <= '0;
            r_rsp_cnt    <= '0;
            r_issue_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (w_hit) begin
                            r_mru[w_req_idx] <= w_hit_way;
                            if (bus.i_req_wen) r_dirty[w_hit_way][w_req_idx] <= 1'b1;
                            else               r_res_rdata <= w_hit_rdata;
                        end else begin
                            r_op_wen     <= bus.i_req_wen;
                            r_req_tag    <= w_req_tag;
                            r_idx        <= w_req_idx;
                            r_word       <= w_req_word;
                            r_mask       <= bus.i_req_mask;
                            r_wdata      <= bus.i_req_wdata;
                            r_way        <= w_vict;
                            r_vtag       <= r_tag[w_vict][w_req_idx];
                            r_cnt        <= '0;
                            r_rsp_cnt    <= '0;
                            r_issue_done <= 1'b0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Wraps back to 0 after the last word, ready for the fill
                    if (bus.i_mem_ready) r_cnt <= r_cnt + CNT_ONE;
                end
                ST_FILL: begin
                    if (w_mem_ren) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (&r_cnt) r_issue_done <= 1'b1;
                    end
                    if (bus.i_mem_valid) r_rsp_cnt <= r_rsp_cnt + CNT_ONE;
                end
                ST_DONE: begin
                    r_valid[r_way][r_idx] <= 1'b1;
                    r_dirty[r_way][r_idx] <= r_op_wen;
                    r_mru[r_idx]          <= r_way;
                    if (!r_op_wen) r_res_rdata <= w_done_old;
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage writes (hit write, refill, replayed write)
    always_ff @(posedge i_clk) begin
        if (w_hit_wr) begin
            r_data[w_hit_way][{w_req_idx, w_req_word}] <= w_hit_merge;
        end
        if ((r_state == ST_FILL) && bus.i_mem_valid) begin
            r_data[r_way][{r_idx, r_rsp_cnt}] <= bus.i_mem_rdata;
        end
        if (r_state == ST_DONE) begin
            r_tag[r_way][r_idx] <= r_req_tag;
            if (r_op_wen) r_data[r_way][{r_idx, r_word}] <= w_done_merge;
        end
    end

    assign bus.o_mem_addr  = w_mem_addr;
    assign bus.o_mem_ren   = w_mem_ren;
    assign bus.o_mem_wen   = w_mem_wen;
    assign bus.o_mem_wdata = w_mem_wdata;
    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_res_rdata = r_res_rdata;

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for the cache: directed vector table, hand-written
// stall and reset-abort sequences, then random traffic checked against an
// LRU-per-set residency model and a flat coherent-memory image.
module tb_cache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cache_if bus();

    cache #(.O(4), .S(5), .W(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    // Backing memory and the coherent view a program would observe
    logic [31:0] mem  [2048];
    logic [31:0] gold [2048];

    function automatic logic [31:0] memf(input int a);
        return 32'(a) * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    // Residency model: per set, slot 0 = least recently used, slot 1 = most
    int ent_tag [32][2];
    bit ent_d   [32][2];
    int ent_n   [32];

    function automatic void model_reset();
        for (int s = 0; s < 32; s++) ent_n[s] = 0;
        for (int i = 0; i < 2048; i++) gold[i] = mem[i];
    endfunction

    function automatic void model_access(input int s, input int t, input bit wen,
                                         output bit hit, output int nwr);
        int pos = -1;
        int tt;
        bit td;
        hit = 1'b0;
        nwr = 0;
        for (int p = 0; p < ent_n[s]; p++) if (ent_tag[s][p] == t) pos = p;
        if (pos >= 0) begin
            hit = 1'b1;
            if (pos == 0 && ent_n[s] == 2) begin
                tt = ent_tag[s][0]; td = ent_d[s][0];
                ent_tag[s][0] = ent_tag[s][1]; ent_d[s][0] = ent_d[s][1];
                ent_tag[s][1] = tt; ent_d[s][1] = td;
            end
        end else if (ent_n[s] < 2) begin
            ent_tag[s][ent_n[s]] = t;
            ent_d[s][ent_n[s]]   = 1'b0;
            ent_n[s]++;
        end else begin
            nwr = ent_d[s][0] ? 4 : 0;
            ent_tag[s][0] = ent_tag[s][1]; ent_d[s][0] = ent_d[s][1];
            ent_tag[s][1] = t;             ent_d[s][1] = 1'b0;
        end
        if (wen) ent_d[s][ent_n[s]-1] = 1'b1;
    endfunction

    // Memory model: counts taken requests, answers reads in order
    int          cnt_rd = 0;
    int          cnt_wr = 0;
    logic [31:0] rsp_q [$];
    bit          hold_low = 1'b0;

    always @(posedge clk) begin
        if (bus.o_mem_ren || bus.o_mem_wen) begin
            check("ren_wen_exclusive", 32'(bus.o_mem_ren & bus.o_mem_wen), 32'd0);
            check("req_needs_ready", 32'(bus.i_mem_ready), 32'd1);
        end
        if (bus.o_mem_ren && bus.i_mem_ready) begin
            rsp_q.push_back(mem[bus.o_mem_addr[12:2]]);
            cnt_rd <= cnt_rd + 1;
        end
        if (bus.o_mem_wen && bus.i_mem_ready) begin
            check("writeback_data", bus.o_mem_wdata, gold[bus.o_mem_addr[12:2]]);
            mem[bus.o_mem_addr[12:2]] <= bus.o_mem_wdata;
            cnt_wr <= cnt_wr + 1;
        end
    end

    always @(negedge clk) begin
        bus.i_mem_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (rsp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            bus.i_mem_valid = 1'b1;
            bus.i_mem_rdata = rsp_q.pop_front();
        end else begin
            bus.i_mem_valid = 1'b0;
            bus.i_mem_rdata = $urandom;
        end
    end

    // One request: accept, optional memory stall, wait for completion
    task automatic xact(input bit wen, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input int hold,
                        output bit hit, output logic [31:0] rd,
                        output int nwr, output int nrd, output bit tmo);
        int wr0, rd0;
        if (hold > 0) hold_low = 1'b1;
        @(negedge clk);
        bus.i_req_addr  = addr;
        bus.i_req_ren   = !wen;
        bus.i_req_wen   = wen;
        bus.i_req_mask  = mask;
        bus.i_req_wdata = wdata;
        wr0 = cnt_wr;
        rd0 = cnt_rd;
        @(posedge clk);
        #1;
        // Scramble inputs: the cache must work from its latched copy
        bus.i_req_ren   = 1'b0;
        bus.i_req_wen   = 1'b0;
        bus.i_req_addr  = $urandom;
        bus.i_req_mask  = 4'($urandom);
        bus.i_req_wdata = $urandom;
        @(negedge clk);
        hit = !bus.o_busy;
        tmo = 1'b0;
        if (!hit) begin
            for (int c = 0; c < hold; c++) @(negedge clk);
            if (hold > 0) begin
                check("stall_no_request", 32'(cnt_rd + cnt_wr - rd0 - wr0), 32'd0);
                hold_low = 1'b0;
            end
            for (int c = 0; c < 400 && bus.o_busy; c++) @(negedge clk);
            if (bus.o_busy) tmo = 1'b1;
        end else begin
            hold_low = 1'b0;
        end
        rd  = bus.o_res_rdata;
        nwr = cnt_wr - wr0;
        nrd = cnt_rd - rd0;
    endtask

    // Predict with the model, run the request, compare everything observable
    task automatic run(input string lbl, input bit wen, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata, input int hold,
                       input bit use_tbl, input bit t_hit, input bit t_chk,
                       input logic [31:0] t_data, input int t_wr);
        bit          exp_hit, hit, tmo;
        int          exp_wr, nwr, nrd, widx;
        logic [31:0] exp_rd, rd, bm;
        widx = int'(addr[12:2]);
        model_access(int'(addr[8:4]), int'(addr[31:9]), wen, exp_hit, exp_wr);
        exp_rd = gold[widx];
        if (wen) begin
            bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
            gold[widx] = (gold[widx] & ~bm) | (wdata & bm);
        end
        xact(wen, addr, mask, wdata, hold, hit, rd, nwr, nrd, tmo);
        if (tmo) check("busy_timeout", 32'(bus.o_busy), 32'd0);
        check("hit", 32'(hit), 32'(exp_hit));
        check("mem_writes", 32'(nwr), exp_hit ? 32'd0 : 32'(exp_wr));
        check("mem_reads", 32'(nrd), exp_hit ? 32'd0 : 32'd4);
        if (!wen) check("rdata", rd, exp_rd);
        if (use_tbl) begin
            check("tbl_hit", 32'(hit), 32'(t_hit));
            check("tbl_writes", 32'(nwr), 32'(t_wr));
            if (t_chk) check("tbl_rdata", rd, t_data);
        end
        $display("%s %s addr=%08h mask=%h wdata=%08h hit=%0b exp_hit=%0b rdata=%08h wr=%0d rd=%0d",
                 lbl, wen ? "W" : "R", addr, mask, wdata, hit, exp_hit, rd, nwr, nrd);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_ren", 32'(bus.o_mem_ren), 32'd0);
        check("rst_wen", 32'(bus.o_mem_wen), 32'd0);
        check("rst_rdata", bus.o_res_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100 && rsp_q.size() > 0; c++) @(negedge clk);
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        bit          wen;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          hold;
        bit          exp_hit;
        bit          chk_data;
        logic [31:0] exp_data;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit wen, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] wdata, input int hold,
                                input bit eh, input bit cd, input logic [31:0] ed, input int ew);
        vec_t v;
        v.rst = rst; v.wen = wen; v.addr = addr; v.mask = mask; v.wdata = wdata;
        v.hold = hold; v.exp_hit = eh; v.chk_data = cd; v.exp_data = ed; v.exp_wr = ew;
        return v;
    endfunction

    initial begin
        vec_t tbl [$];
        int   rd0, wr0;
        bit   hw;
        logic [31:0] ra;

        bus.i_req_addr  = '0;
        bus.i_req_ren   = 1'b0;
        bus.i_req_wen   = 1'b0;
        bus.i_req_mask  = '0;
        bus.i_req_wdata = '0;
        for (int i = 0; i < 2048; i++) mem[i] = memf(i);
        model_reset();

        // Power-on reset state
        @(negedge clk);
        check("por_busy", 32'(bus.o_busy), 32'd0);
        check("por_ren", 32'(bus.o_mem_ren), 32'd0);
        check("por_wen", 32'(bus.o_mem_wen), 32'd0);
        check("por_rdata", bus.o_res_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: rst, wen, addr, mask, wdata, hold, hit, chk, data, writes
        tbl.push_back(mk(0, 0, 32'h000, 4'h0, 32'h0,          0, 0, 1, memf(0), 0));
        tbl.push_back(mk(0, 0, 32'h000, 4'h0, 32'h0,          0, 1, 1, memf(0), 0));
        tbl.push_back(mk(0, 0, 32'h00A, 4'h0, 32'h0,          0, 1, 1, memf(2), 0));
        tbl.push_back(mk(0, 1, 32'h200, 4'hF, 32'hDEADBEEF,   0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'h200, 4'hF, 32'hBEEFCAFE,   0, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 4'h0, 32'h0,          0, 1, 1, 32'hBEEFCAFE, 0));
        tbl.push_back(mk(0, 1, 32'h400, 4'hF, 32'hCAFEBEEF,   0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, 32'h200, 4'hC, 32'hBEEF0000,   0, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 4'h0, 32'h0,          0, 1, 1, 32'hBEEFCAFE, 0));
        tbl.push_back(mk(0, 1, 32'h200, 4'h3, 32'h0000CAFE,   0, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h200, 4'h0, 32'h0,          0, 1, 1, 32'hBEEFCAFE, 0));
        tbl.push_back(mk(0, 0, 32'h600, 4'h0, 32'h0,          6, 0, 1, memf(32'h180), 4));
        tbl.push_back(mk(0, 0, 32'h400, 4'h0, 32'h0,          0, 0, 1, 32'hCAFEBEEF, 4));
        tbl.push_back(mk(0, 0, 32'h200, 4'h0, 32'h0,          0, 0, 1, 32'hBEEFCAFE, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(k == 0, 1, 32'h200 + 32'(4*k), 4'hF, 32'(32'h11111111 * k),
                             0, k != 0, 0, 32'h0, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, 32'h400 + 32'(4*k), 4'hF, 32'(32'h11111111 * (k + 4)),
                             0, k != 0, 0, 32'h0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 0, (k < 4 ? 32'h200 : 32'h3F0) + 32'(4*k), 4'h0, 32'h0,
                             0, 1, 1, 32'(32'h11111111 * k), 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) reset_dut();
            run("vec", tbl[i].wen, tbl[i].addr, tbl[i].mask, tbl[i].wdata, tbl[i].hold,
                1'b1, tbl[i].exp_hit, tbl[i].chk_data, tbl[i].exp_data, tbl[i].exp_wr);
        end

        // Reset in the middle of a refill: abort, no further memory traffic
        @(negedge clk);
        bus.i_req_addr = 32'h1000;
        bus.i_req_ren  = 1'b1;
        rd0 = cnt_rd;
        @(posedge clk);
        #1;
        bus.i_req_ren = 1'b0;
        for (int c = 0; c < 200 && (cnt_rd - rd0) < 2; c++) @(negedge clk);
        check("abort_reached_fill", 32'((cnt_rd - rd0) >= 2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_ren", 32'(bus.o_mem_ren), 32'd0);
        check("abort_wen", 32'(bus.o_mem_wen), 32'd0);
        check("abort_rdata", bus.o_res_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd0 = cnt_rd;
        wr0 = cnt_wr;
        repeat (10) @(negedge clk);
        check("abort_quiet", 32'(cnt_rd + cnt_wr - rd0 - wr0), 32'd0);
        check("abort_idle", 32'(bus.o_busy), 32'd0);
        for (int c = 0; c < 100 && rsp_q.size() > 0; c++) @(negedge clk);
        model_reset();
        run("post_abort", 1'b0, 32'h1000, 4'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1, mem[32'h400], 0);
        run("post_abort", 1'b0, 32'h200,  4'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

        // Random traffic over 4 tags x 4 sets to force conflicts and evictions
        for (int n = 0; n < 250; n++) begin
            hw = 1'($urandom_range(0, 1));
            ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) |
                 32'($urandom_range(0, 15));
            run("rnd", hw, ra, 4'($urandom), $urandom,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0,
                1'b0, 1'b0, 1'b0, 32'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have these parameters (name, default, meaning): O 4 offset bits (16-byte line); S 5 index bits (32 sets); W 2 ways; tag width fixed at 32-O-S = 23 bits.
REQ-002 SHALL have one clock and reset is asynchronous and active-low; ports (name direction width meaning) are listed in REQ-003 to REQ-017.
REQ-003 i_clk  in  1  clock; all state changes on rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_mem_ready  in  1  memory can accept a request this cycle.
REQ-006 o_mem_addr  out  32  word-aligned memory address.
REQ-007 o_mem_ren  out  1  memory read request.
REQ-008 o_mem_wen  out  1  memory write request (full word, byte mask fixed 4'b1111).
REQ-009 o_mem_wdata  out  32  memory write data.
REQ-010 i_mem_rdata  in  32  memory read data.
REQ-011 i_mem_valid  in  1  i_mem_rdata valid; responses return in request order.
REQ-012 o_busy  out  1  cache is servicing a miss; new requests ignored.
REQ-013 i_req_addr  in  32  byte address, bits [1:0] ignored.
REQ-014 i_req_ren  in  1  read request.
REQ-015 i_req_wen  in  1  write request; has priority if both ren and wen are high.
REQ-016 i_req_mask  in  4  byte enables for writes; ignored for reads.
REQ-017 i_req_wdata  in  32  write data. o_res_rdata  out  32  read result word.

Function
REQ-018 SHALL be 2-way set associative, 32 sets, 4 words per line, write-back, write-allocate; address split tag[31:9], index[8:4], word[3:2].
REQ-019 SHALL keep a valid bit, dirty bit and tag per way, plus one MRU bit per set.
REQ-020 SHALL accept a request on a rising edge when o_busy=0 and ren or wen=1; it SHALL latch addr, mask, wdata and op internally, so inputs may change afterwards.
REQ-021 Read hit: o_res_rdata SHALL hold the full 32-bit word in the cycle after acceptance; o_busy stays 0.
REQ-022 Write hit: each byte with mask=1 SHALL be written in the accepting edge; line dirty=1; o_busy stays 0.
REQ-023 Hit or fill completion SHALL set the set's MRU bit to the way used.
REQ-024 Miss: o_busy SHALL be 1 from the cycle after acceptance until completion.
REQ-025 Victim selection: first invalid way (way 0 before way 1); otherwise the way that is not MRU.
REQ-026 FSM states SHALL be IDLE, WRITEBACK, FILL, DONE.
REQ-027 IDLE to WRITEBACK on a miss with a valid dirty victim; IDLE to FILL otherwise.
REQ-028 WRITEBACK SHALL issue 4 writes of the victim words to {victim_tag,index,k,2'b00}, k=0..3 in order.
REQ-029 Each memory request SHALL be issued only in a cycle with i_mem_ready=1, with ren/wen high for that single cycle; addr and data are held until the request is taken.
REQ-030 After the 4th write is taken, the FSM SHALL go to FILL.
REQ-031 FILL SHALL issue 4 reads to {req_tag,index,k,2'b00}, k=0..3; each i_mem_valid word is stored into word k (response counter); after the 4th response the FSM goes to DONE.
REQ-032 DONE SHALL set tag, valid=1 and dirty=0, then apply the pending op as a hit (write merges mask, dirty=1; read loads o_res_rdata), update MRU, clear o_busy and return to IDLE.
REQ-033 o_res_rdata SHALL be valid in the first cycle o_busy=0 after a miss and hold until the next read completes.
REQ-034 o_mem_ren and o_mem_wen SHALL never be high simultaneously and SHALL be 0 in IDLE and DONE.

Reset
REQ-035 i_rst_n=0 SHALL immediately (asynchronously) clear all valid, dirty and MRU bits, set FSM to IDLE, and drive o_busy=0, o_mem_ren=0, o_mem_wen=0, o_res_rdata=0; tag and data arrays need no reset.
REQ-036 Reset mid-miss SHALL abort the operation with no further memory requests; an in-flight memory response arriving after reset SHALL be ignored.

Verification
REQ-037 After reset, read 0x00000000: busy rises, reads to 0x0/0x4/0x8/0xC, busy falls, rdata=mem[0]; repeated read and read of 0x0000000A are hits (0x0A returns mem word 0x8).
REQ-038 Write 0x00000200=DEADBEEF (miss, fill, no writeback); write BEEFCAFE (hit); read 0x200 -> BEEFCAFE with no memory traffic.
REQ-039 Then write 0x00000400=CAFEBEEF: evicts clean line tag 0 (non-MRU), no memory writes; write 0x200 mask 1100 data BEEF0000 is a hit; read -> BEEFCAFE; write mask 0011 data 0000CAFE; read -> BEEFCAFE.
REQ-040 Fill test after reset: write index 0 tag1 words 0..3 = 00000000/11111111/22222222/33333333 and tag2 = 44444444..77777777; two misses, then all 8 read-backs are hits with exact values.
REQ-041 With both ways of set 0 dirty (0x200, 0x400), access 0x600: 4 memory writes of the non-MRU line, then 4 reads; a later read of the evicted address returns the previously written data.
REQ-042 Hold i_mem_ready low during a miss: no ren/wen is issued; the sequence resumes correctly when ready returns; reset asserted mid-FILL returns to IDLE with busy=0.
